// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, default 50 MHz cycle constants, parity helper.
package ps2_pkg;

  // Host-to-device transmitter states, also exposed on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_ACK   = 3'd5
  } state_t;

  // Defaults for a 50 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us request-to-send hold
  localparam int DEF_TIMEOUT_CYCLES = 100000;  // 2 ms max gap between device edges
  localparam int DEF_FILTER_LEN     = 8;       // ps2c glitch filter depth

  // Odd parity bit for a data byte: makes the 9-bit total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter and falling-edge detector for the PS/2 clock pin.
// The filtered level only flips once every tap agrees, so short spikes are ignored.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic f_c,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] sh_q, sh_d;
  logic                  f_c_q, f_c_d;

  // Shift in the raw pin; filtered level follows only unanimous taps.
  always_comb begin
    sh_d  = {sh_q[FILTER_LEN-2:0], pin};
    f_c_d = f_c_q;
    if (&sh_q) begin
      f_c_d = 1'b1;
    end else if (~|sh_q) begin
      f_c_d = 1'b0;
    end
  end

  // Filter state; the idle bus is pulled high, so reset to the high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '1;
      f_c_q <= 1'b1;
    end else begin
      sh_q  <= sh_d;
      f_c_q <= f_c_d;
    end
  end

  assign f_c       = f_c_q;
  assign fall_edge = f_c_q & ~f_c_d;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start bit, 8 data bits,
// odd parity, stop bit, then samples the device ACK. Lines are only ever
// pulled low or released; pull-ups supply the high level.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err,
  output state_t     state_dbg
);

  // One down-counter serves both the inhibit hold and the edge timeout.
  localparam int C_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(C_MAX);
  localparam logic [CW-1:0] INHIBIT_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [3:0]    n_q, n_d;
  logic [8:0]    b_q, b_d;
  logic          c_oe_q, c_oe_d;
  logic          d_oe_q, d_oe_d;
  logic          tick_q, tick_d;
  logic          ack_err_q, ack_err_d;
  logic          tx_idle_q, tx_idle_d;
  logic          d_meta_q, d_meta_d;
  logic          d_sync_q, d_sync_d;
  logic          f_c;
  logic          fall_edge;
  logic          timeout;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .pin      (ps2c),
    .f_c      (f_c),
    .fall_edge(fall_edge)
  );

  // Next-state logic: transfer sequencing, shifting, timeout and ACK capture.
  always_comb begin
    state_d   = state_q;
    c_d       = (c_q != '0) ? c_q - CW'(1) : c_q;
    n_d       = n_q;
    b_d       = b_q;
    tick_d    = 1'b0;
    ack_err_d = ack_err_q;
    d_meta_d  = ps2d;
    d_sync_d  = d_meta_q;
    // A device edge in the same cycle as expiry takes priority over the abort.
    timeout   = (state_q inside {ST_START, ST_DATA, ST_STOP, ST_ACK}) &&
                !fall_edge && (c_q == '0);

    unique case (state_q)
      ST_IDLE: begin
        // tx_idle_q is still low in the cycle of a done tick, so that strobe is dropped.
        if (wr_ps2 && tx_idle_q) begin
          b_d     = {odd_parity(din), din};
          c_d     = INHIBIT_LOAD;
          state_d = ST_RTS;
        end
      end
      ST_RTS: begin
        // Our own low drive on ps2c makes edges here; they are deliberately ignored.
        if (c_q == '0) begin
          c_d     = TIMEOUT_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (fall_edge) begin
          n_d     = 4'd8;
          c_d     = TIMEOUT_LOAD;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fall_edge) begin
          b_d = {1'b0, b_q[8:1]};
          c_d = TIMEOUT_LOAD;
          if (n_q == 4'd0) begin
            state_d = ST_STOP;
          end else begin
            n_d = n_q - 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (fall_edge) begin
          c_d     = TIMEOUT_LOAD;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Device pulls ps2d low to acknowledge; a high level means no ACK.
        if (fall_edge) begin
          ack_err_d = d_sync_q;
          tick_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (timeout) begin
      ack_err_d = 1'b1;
      tick_d    = 1'b1;
      state_d   = ST_IDLE;
    end

    // Line drivers and status are registered from the next state.
    c_oe_d    = (state_d == ST_RTS);
    d_oe_d    = (state_d == ST_START) || ((state_d == ST_DATA) && !b_d[0]);
    tx_idle_d = (state_d == ST_IDLE) && !tick_d;
  end

  // FSM and datapath registers; reset releases both lines on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      c_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      tick_q    <= 1'b0;
      ack_err_q <= 1'b0;
      tx_idle_q <= 1'b1;
      d_meta_q  <= 1'b1;
      d_sync_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      n_q       <= n_d;
      b_q       <= b_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      tick_q    <= tick_d;
      ack_err_q <= ack_err_d;
      tx_idle_q <= tx_idle_d;
      d_meta_q  <= d_meta_d;
      d_sync_q  <= d_sync_d;
    end
  end

  assign ps2c         = c_oe_q ? 1'b0 : 1'bz;
  assign ps2d         = d_oe_q ? 1'b0 : 1'bz;
  assign tx_idle      = tx_idle_q;
  assign tx_done_tick = tick_q;
  assign ack_err      = ack_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model with pull-ups clocks the frame out,
// records the bits it samples on its rising edges and answers with or without ACK.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int TMO  = 400;
  localparam int FLEN = 8;

  localparam int M_NORMAL = 0;  // plain transfer
  localparam int M_REWR   = 1;  // extra wr_ps2 pulse mid-data
  localparam int M_RESET  = 2;  // reset asserted mid-data
  localparam int M_SILENT = 3;  // device never clocks

  // ---------------- clock / reset / wiring ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_oe = 1'b0;
  logic       dev_d_oe = 1'b0;
  logic       tx_idle, tx_done_tick, ack_err;
  state_t     state_dbg;
  wire        ps2c, ps2d;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_oe ? 1'b0 : 1'bz;
  assign ps2d = dev_d_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .ack_err     (ack_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  int          tick_cnt = 0;
  logic        tick_err = 1'b0;
  logic [10:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (($countones(d) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Done-tick monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (tx_done_tick === 1'b1) begin
      tick_cnt++;
      tick_err = ack_err;
    end
  end

  // ---------------- driver / device model ----------------
  task automatic xfer(input logic [7:0] d, input bit ack_ok, input int half, input int mode);
    int          t0;
    int          low;
    int          n;
    logic [10:0] got;
    logic [10:0] exp;
    t0  = tick_cnt;
    got = '0;
    exp_q.push_back(frame_of(d));

    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'($urandom);  // byte must already be latched

    // Host request-to-send: ps2c held low for the inhibit time.
    low = 0;
    while (ps2c === 1'b0 && low < INH + 20) begin
      low++;
      @(negedge clk);
    end
    check_eq("rts_len", low, INH);
    got[0] = ps2d;  // start bit, sampled as the host releases the clock

    if (mode == M_SILENT) begin
      // First clock in start counts as clock 1; abort tick lands on clock TMO+1.
      n = 1;
      while (tx_done_tick !== 1'b1 && n < TMO + 50) begin
        @(negedge clk);
        n++;
      end
      check_eq("timeout_len", n, TMO + 1);
      // A write in the tick cycle must be dropped.
      wr_ps2 = 1'b1;
      din    = 8'hA5;
      @(negedge clk);
      wr_ps2 = 1'b0;
      @(negedge clk);
      check_eq("drop_at_tick_c", ps2c, 1'b1);
      check_eq("to_idle", tx_idle, 1'b1);
      check_eq("to_d", ps2d, 1'b1);
      check_eq("to_start_bit", got[0], 1'b0);
      check_eq("to_ticks", tick_cnt - t0, 1);
      check_eq("to_err", tick_err, 1'b1);
      exp = exp_q.pop_front();
      return;
    end

    repeat (half) @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      dev_c_oe = 1'b1;
      for (int j = 0; j < half; j++) begin
        if (mode == M_REWR && k == 5 && j == 0) begin
          din    = 8'h12;
          wr_ps2 = 1'b1;
        end
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
      dev_c_oe = 1'b0;
      if (k <= 10) got[k] = ps2d;
      if (k == 10 && ack_ok) dev_d_oe = 1'b1;
      if (k == 12) dev_d_oe = 1'b0;
      if (mode == M_RESET && k == 5) begin
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_c", ps2c, 1'b1);
        check_eq("rst_d", ps2d, 1'b1);
        check_eq("rst_idle", tx_idle, 1'b1);
        reset = 1'b0;
        repeat (TMO + 20) @(negedge clk);
        check_eq("rst_no_tick", tick_cnt - t0, 0);
        exp = exp_q.pop_front();
        return;
      end
      repeat (half) @(negedge clk);
    end

    n = 0;
    while (tx_idle !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    check_eq("frame", got, exp);
    check_eq("ticks", tick_cnt - t0, 1);
    check_eq("tick_err", tick_err, !ack_ok);
    check_eq("end_idle", tx_idle, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("err_hold", ack_err, !ack_ok);
    check_eq("end_c", ps2c, 1'b1);
    check_eq("end_d", ps2d, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_tx_idle", tx_idle, 1'b1);
    check_eq("rst_tick", tx_done_tick, 1'b0);
    check_eq("rst_ack_err", ack_err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_c", ps2c, 1'b1);
    check_eq("post_rst_d", ps2d, 1'b1);
    check_eq("post_rst_idle", tx_idle, 1'b1);

    xfer(8'hED, 1'b1, 30, M_NORMAL);
    xfer(8'h00, 1'b1, 25, M_NORMAL);
    xfer(8'hFF, 1'b1, 35, M_NORMAL);
    xfer(8'h5A, 1'b0, 30, M_NORMAL);   // no ACK from device
    xfer(8'h3C, 1'b1, 30, M_REWR);
    xfer(8'h00, 1'b1, 30, M_RESET);
    xfer(8'hC3, 1'b1, 28, M_NORMAL);   // normal transfer after reset
    xfer(8'h81, 1'b1, 30, M_SILENT);
    xfer(8'h42, 1'b1, 30, M_NORMAL);   // recovers after a timeout

    for (int i = 0; i < 10; i++) begin
      xfer(8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(20, 40), M_NORMAL);
    end

    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
